// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time, and holds the result for decode.
// Optional macro IFU_MISALIGN_CHECK_EN turns a misaligned redirect target into a sticky FAULT state.
`timescale 1ns/1ps
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_snpc,
    output logic        fetch_fault
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [1:0] S_FAULT = 2'd3;
`endif

    logic [1:0]  state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_r, inst_r_nx;
    logic        kill, kill_nx;
    logic [31:0] target;
    logic        misalign;

`ifdef IFU_MISALIGN_CHECK_EN
    assign target   = redirect_target;
    assign misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    // Without the checker, low target bits are simply dropped so pc stays word-aligned.
    assign target   = redirect_target & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        pc_nx     = pc;
        inst_r_nx = inst_r;
        kill_nx   = kill;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nx = target;
                    if (imem_req_ready) begin
                        state_nx = S_WAIT;
                        kill_nx  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nx = target;
                    if (imem_rsp_valid) begin
                        state_nx = S_REQ;
                        kill_nx  = 1'b0;
                    end else begin
                        kill_nx = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    kill_nx = 1'b0;
                    if (kill) begin
                        state_nx = S_REQ;
                    end else begin
                        inst_r_nx = imem_rsp_data;
                        state_nx  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A redirect wins over a coincident consume: the held instruction is dropped.
                if (redirect_valid) begin
                    pc_nx    = target;
                    state_nx = S_REQ;
                end else if (inst_ready) begin
                    pc_nx    = pc + 32'd4;
                    state_nx = S_REQ;
                end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            S_FAULT: begin
                state_nx = S_FAULT;
            end
`endif
            default: begin
                state_nx = S_REQ;
            end
        endcase
        if (misalign) begin
            state_nx = 2'd3;
            kill_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            inst_r <= NOP_INST;
            kill   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state  <= state_nx;
            pc     <= pc_nx;
            inst_r <= inst_r_nx;
            kill   <= kill_nx;
        end
    end

    // Request valid is masked during reset so nothing is issued before the first rst=0 cycle.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign inst           = inst_valid ? inst_r : NOP_INST;
    assign inst_pc        = pc;
    assign inst_snpc      = pc + 32'd4;

`ifdef IFU_MISALIGN_CHECK_EN
    assign fetch_fault = (state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
